// File: rtl/xc_rf_wb_seq.sv
// Writeback sequencer: result handshake, two forwarding stages and a commit
// stage for the register file, plus a pending-destination scoreboard for issue.
module xc_rf_wb_seq (
    input  logic        clock,
    input  logic        resetn,

    input  logic        iss_valid,
    output logic        iss_ready,
    input  logic [4:0]  iss_rd_addr,
    input  logic        iss_rd_wen,
    input  logic        iss_wide,
    input  logic [4:0]  iss_rs1_addr,
    input  logic [4:0]  iss_rs2_addr,
    input  logic [4:0]  iss_rs3_addr,

    input  logic        res_valid,
    output logic        res_ready,
    input  logic [4:0]  res_addr,
    input  logic        res_wide,
    input  logic [31:0] res_wdata,
    input  logic [31:0] res_wdata_hi,

    input  logic        flush,
    input  logic        hold,

    output logic        fwd_0_wen,
    output logic        fwd_0_wide,
    output logic [4:0]  fwd_0_addr,
    output logic [31:0] fwd_0_wdata,
    output logic [31:0] fwd_0_wdata_hi,

    output logic        fwd_1_wen,
    output logic        fwd_1_wide,
    output logic [4:0]  fwd_1_addr,
    output logic [31:0] fwd_1_wdata,
    output logic [31:0] fwd_1_wdata_hi,

    output logic        rd_wen,
    output logic        rd_wide,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata,
    output logic [31:0] rd_wdata_hi
);

    typedef struct packed {
        logic        wen;
        logic        wide;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] wdata_hi;
    } stage_t;

    stage_t      r_fwd_0;
    stage_t      r_fwd_1;
    stage_t      r_rd;
    stage_t      w_fwd_0_next;

    logic [31:0] r_pending;
    logic [31:0] w_pending_next;
    logic [31:0] w_clr_mask;
    logic [31:0] w_dst_mask;
    logic [31:0] w_set_mask;
    logic [31:0] w_pend_eff;
    logic        w_accept;
    logic        w_src_hazard;
    logic        w_waw_hazard;

    // One-hot mask of a destination; a wide destination covers the even/odd pair.
    // x0 is never tracked.
    function automatic logic [31:0] dest_mask(input logic [4:0] addr, input logic wide);
        logic [31:0] m;
        m = 32'd0;
        if (wide) begin
            m[{addr[4:1], 1'b0}] = 1'b1;
            m[{addr[4:1], 1'b1}] = 1'b1;
        end else begin
            m[addr] = 1'b1;
        end
        m[0] = 1'b0;
        return m;
    endfunction

    // Handshake: valid/ready, a transfer happens on a cycle where both are high.
    // Neither ready depends on its own valid.
    assign res_ready = !hold && !flush;
    assign w_accept  = res_valid && res_ready;

    always_comb begin
        w_clr_mask     = 32'd0;
        w_dst_mask     = 32'd0;
        w_set_mask     = 32'd0;
        w_pend_eff     = 32'd0;
        w_src_hazard   = 1'b0;
        w_waw_hazard   = 1'b0;
        iss_ready      = 1'b0;
        w_pending_next = 32'd0;

        if (w_accept) begin
            w_clr_mask = dest_mask(res_addr, res_wide);
        end
        // A result accepted this cycle is already forwardable, so it no longer blocks issue.
        w_pend_eff = r_pending & ~w_clr_mask;

        if (iss_rd_wen) begin
            w_dst_mask = dest_mask(iss_rd_addr, iss_wide);
        end

        w_src_hazard = w_pend_eff[iss_rs1_addr] | w_pend_eff[iss_rs2_addr]
                     | w_pend_eff[iss_rs3_addr];
        w_waw_hazard = |(w_pend_eff & w_dst_mask);
        iss_ready    = !flush && !w_src_hazard && !w_waw_hazard;

        if (iss_valid && iss_ready) begin
            w_set_mask = w_dst_mask;
        end

        // Set is applied after clear so a same-cycle set of a cleared bit wins.
        if (flush) begin
            w_pending_next = 32'd0;
        end else begin
            w_pending_next = (r_pending & ~w_clr_mask) | w_set_mask;
        end
        w_pending_next[0] = 1'b0;
    end

    // Bubbles only drop wen: the register file compares forwarding addresses
    // without looking at wen, and a stale entry is still the youngest value.
    always_comb begin
        w_fwd_0_next     = r_fwd_0;
        w_fwd_0_next.wen = 1'b0;
        if (w_accept) begin
            w_fwd_0_next.wen      = (res_addr != 5'd0) || res_wide;
            w_fwd_0_next.wide     = res_wide;
            w_fwd_0_next.addr     = res_addr;
            w_fwd_0_next.wdata    = res_wdata;
            w_fwd_0_next.wdata_hi = res_wdata_hi;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pending <= 32'd0;
            r_fwd_0   <= '0;
            r_fwd_1   <= '0;
            r_rd      <= '0;
        end else begin
            r_pending <= w_pending_next;
            if (!hold) begin
                r_fwd_0 <= w_fwd_0_next;
                r_fwd_1 <= r_fwd_0;
                r_rd    <= r_fwd_1;
            end
        end
    end

    assign fwd_0_wen      = r_fwd_0.wen;
    assign fwd_0_wide     = r_fwd_0.wide;
    assign fwd_0_addr     = r_fwd_0.addr;
    assign fwd_0_wdata    = r_fwd_0.wdata;
    assign fwd_0_wdata_hi = r_fwd_0.wdata_hi;

    assign fwd_1_wen      = r_fwd_1.wen;
    assign fwd_1_wide     = r_fwd_1.wide;
    assign fwd_1_addr     = r_fwd_1.addr;
    assign fwd_1_wdata    = r_fwd_1.wdata;
    assign fwd_1_wdata_hi = r_fwd_1.wdata_hi;

    assign rd_wen         = r_rd.wen;
    assign rd_wide        = r_rd.wide;
    assign rd_addr        = r_rd.addr;
    assign rd_wdata       = r_rd.wdata;
    assign rd_wdata_hi    = r_rd.wdata_hi;

endmodule

// File: tb/tb_xc_rf_wb_seq.sv
// Bench for xc_rf_wb_seq: directed stimulus, commit scoreboard and direct checks.
module tb_xc_rf_wb_seq;

    logic        clock;
    logic        resetn;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rd_addr;
    logic        iss_rd_wen;
    logic        iss_wide;
    logic [4:0]  iss_rs1_addr;
    logic [4:0]  iss_rs2_addr;
    logic [4:0]  iss_rs3_addr;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_addr;
    logic        res_wide;
    logic [31:0] res_wdata;
    logic [31:0] res_wdata_hi;
    logic        flush;
    logic        hold;
    logic        fwd_0_wen, fwd_0_wide;
    logic [4:0]  fwd_0_addr;
    logic [31:0] fwd_0_wdata, fwd_0_wdata_hi;
    logic        fwd_1_wen, fwd_1_wide;
    logic [4:0]  fwd_1_addr;
    logic [31:0] fwd_1_wdata, fwd_1_wdata_hi;
    logic        rd_wen, rd_wide;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata, rd_wdata_hi;

    int tests_run = 0;
    int tests_failed = 0;
    logic edge_hold = 1'b0;
    logic [69:0] exp_q[$];

    xc_rf_wb_seq dut (
        .clock(clock), .resetn(resetn),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd_addr(iss_rd_addr),
        .iss_rd_wen(iss_rd_wen), .iss_wide(iss_wide), .iss_rs1_addr(iss_rs1_addr),
        .iss_rs2_addr(iss_rs2_addr), .iss_rs3_addr(iss_rs3_addr),
        .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr),
        .res_wide(res_wide), .res_wdata(res_wdata), .res_wdata_hi(res_wdata_hi),
        .flush(flush), .hold(hold),
        .fwd_0_wen(fwd_0_wen), .fwd_0_wide(fwd_0_wide), .fwd_0_addr(fwd_0_addr),
        .fwd_0_wdata(fwd_0_wdata), .fwd_0_wdata_hi(fwd_0_wdata_hi),
        .fwd_1_wen(fwd_1_wen), .fwd_1_wide(fwd_1_wide), .fwd_1_addr(fwd_1_addr),
        .fwd_1_wdata(fwd_1_wdata), .fwd_1_wdata_hi(fwd_1_wdata_hi),
        .rd_wen(rd_wen), .rd_wide(rd_wide), .rd_addr(rd_addr),
        .rd_wdata(rd_wdata), .rd_wdata_hi(rd_wdata_hi)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_rd_addr = 0; iss_rd_wen = 0; iss_wide = 0;
        iss_rs1_addr = 0; iss_rs2_addr = 0; iss_rs3_addr = 0;
        res_valid = 0; res_addr = 0; res_wide = 0; res_wdata = 0; res_wdata_hi = 0;
        flush = 0; hold = 0;
    endtask

    task automatic drive_issue(input logic [4:0] rd, input logic wide);
        iss_valid = 1; iss_rd_wen = 1; iss_rd_addr = rd; iss_wide = wide;
    endtask

    // Presents a result; commits expected at the rd port are queued here.
    task automatic drive_result(input logic [4:0] addr, input logic wide,
                                input logic [31:0] lo, input logic [31:0] hi,
                                input logic expect_commit);
        res_valid = 1; res_addr = addr; res_wide = wide;
        res_wdata = lo; res_wdata_hi = hi;
        if (expect_commit) exp_q.push_back({wide, addr, hi, lo});
    endtask

    // Monitor: every fresh commit at the rd port must match the oldest queued result.
    always @(posedge clock) edge_hold = hold;

    always @(negedge clock) begin
        logic [69:0] exp;
        if (resetn && rd_wen && !edge_hold) begin
            if (exp_q.size() == 0) begin
                check("unexpected_commit_addr", {27'd0, rd_addr}, 32'hFFFF_FFFF);
            end else begin
                exp = exp_q.pop_front();
                check("commit_wide", {31'd0, rd_wide}, {31'd0, exp[69]});
                check("commit_addr", {27'd0, rd_addr}, {27'd0, exp[68:64]});
                check("commit_hi", rd_wdata_hi, exp[63:32]);
                check("commit_lo", rd_wdata, exp[31:0]);
            end
        end
    end

    initial begin
        int cnt;
        idle_inputs();
        resetn = 0;
        repeat (2) tick();
        check("rst_fwd0_wen", {31'd0, fwd_0_wen}, 0);
        check("rst_fwd0_addr", {27'd0, fwd_0_addr}, 0);
        check("rst_rd_wen", {31'd0, rd_wen}, 0);
        check("rst_rd_wdata", rd_wdata, 0);
        check("rst_pending", dut.r_pending, 0);
        check("rst_res_ready", {31'd0, res_ready}, 1);
        check("rst_iss_ready", {31'd0, iss_ready}, 1);
        resetn = 1;
        tick();

        // Basic commit
        drive_issue(5, 0); #1;
        check("basic_iss_ready", {31'd0, iss_ready}, 1);
        tick(); idle_inputs();
        check("basic_pending_set", dut.r_pending, 32'h0000_0020);
        iss_rs1_addr = 5; #1;
        check("basic_rs1_blocked", {31'd0, iss_ready}, 0);
        iss_rs1_addr = 0;
        drive_result(5, 0, 32'hDEAD_BEEF, 0, 1); #1;
        check("basic_res_ready", {31'd0, res_ready}, 1);
        tick(); idle_inputs();
        check("basic_pending_clr", dut.r_pending, 0);
        check("basic_fwd0_wen", {31'd0, fwd_0_wen}, 1);
        check("basic_fwd0_addr", {27'd0, fwd_0_addr}, 5);
        check("basic_fwd0_wdata", fwd_0_wdata, 32'hDEAD_BEEF);
        check("basic_fwd1_wen_n1", {31'd0, fwd_1_wen}, 0);
        check("basic_rd_wen_n1", {31'd0, rd_wen}, 0);
        tick();
        check("basic_fwd1_wen", {31'd0, fwd_1_wen}, 1);
        check("basic_fwd0_bubble", {31'd0, fwd_0_wen}, 0);
        tick();
        check("basic_rd_wen", {31'd0, rd_wen}, 1);
        check("basic_rd_addr", {27'd0, rd_addr}, 5);
        tick();
        check("basic_rd_wen_off", {31'd0, rd_wen}, 0);

        // Scoreboard gating with bypass; set of the same bit wins over the clear
        drive_issue(7, 0);
        tick(); idle_inputs();
        check("gate_pending7", dut.r_pending, 32'h0000_0080);
        drive_issue(7, 0); iss_rs2_addr = 7; #1;
        check("gate_blocked_a", {31'd0, iss_ready}, 0);
        tick();
        check("gate_blocked_b", {31'd0, iss_ready}, 0);
        drive_result(7, 0, 32'h7777_0007, 0, 1); #1;
        check("gate_bypass_ready", {31'd0, iss_ready}, 1);
        tick(); idle_inputs();
        check("gate_set_wins", dut.r_pending, 32'h0000_0080);

        // Wide write
        drive_issue(10, 1); #1;
        check("wide_iss_ready", {31'd0, iss_ready}, 1);
        tick(); idle_inputs();
        check("wide_pending_pair", dut.r_pending, 32'h0000_0C80);
        iss_rs3_addr = 11; #1;
        check("wide_rs3_blocked", {31'd0, iss_ready}, 0);
        iss_rs3_addr = 0;
        drive_result(11, 1, 32'h0000_1111, 32'h0000_2222, 1);
        tick(); idle_inputs();
        check("wide_pending_clr", dut.r_pending, 32'h0000_0080);
        check("wide_fwd0_wide", {31'd0, fwd_0_wide}, 1);
        repeat (2) tick();
        check("wide_rd_wide", {31'd0, rd_wide}, 1);
        check("wide_rd_addr", {27'd0, rd_addr}, 11);
        check("wide_rd_lo", rd_wdata, 32'h0000_1111);
        check("wide_rd_hi", rd_wdata_hi, 32'h0000_2222);

        // Sticky bubbles
        drive_result(3, 0, 32'h0000_000A, 0, 1);
        tick(); idle_inputs();
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rd_wen) cnt++;
        end
        check("sticky_rd_once", cnt, 1);
        check("sticky_fwd0_wen", {31'd0, fwd_0_wen}, 0);
        check("sticky_fwd0_addr", {27'd0, fwd_0_addr}, 3);
        check("sticky_fwd0_data", fwd_0_wdata, 32'h0000_000A);
        check("sticky_fwd1_wen", {31'd0, fwd_1_wen}, 0);
        check("sticky_fwd1_addr", {27'd0, fwd_1_addr}, 3);
        check("sticky_fwd1_data", fwd_1_wdata, 32'h0000_000A);

        // Hold then flush with three pending bits and a result in fwd_1
        drive_issue(20, 0); tick();
        drive_issue(21, 0); tick(); idle_inputs();
        check("flush_pending3", dut.r_pending, 32'h0030_0080);
        drive_result(12, 0, 32'h0000_C0C0, 0, 1);
        tick(); idle_inputs();
        tick();
        check("hold_fwd1_loaded", {31'd0, fwd_1_wen}, 1);
        hold = 1;
        drive_result(13, 0, 32'h0000_0BAD, 0, 0); #1;
        check("hold_res_ready", {31'd0, res_ready}, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_fwd1_wen", {31'd0, fwd_1_wen}, 1);
            check("hold_fwd1_addr", {27'd0, fwd_1_addr}, 12);
            check("hold_fwd0_wen", {31'd0, fwd_0_wen}, 0);
            check("hold_rd_wen", {31'd0, rd_wen}, 0);
        end
        check("hold_pending", dut.r_pending, 32'h0030_0080);
        idle_inputs();
        flush = 1; #1;
        check("flush_res_ready", {31'd0, res_ready}, 0);
        check("flush_iss_ready", {31'd0, iss_ready}, 0);
        tick(); idle_inputs();
        check("flush_pending_zero", dut.r_pending, 0);
        check("flush_rd_wen", {31'd0, rd_wen}, 1);
        check("flush_rd_addr", {27'd0, rd_addr}, 12);

        // x0 narrow write is accepted but never written
        drive_result(0, 0, 32'h0000_0055, 0, 0); #1;
        check("x0_res_ready", {31'd0, res_ready}, 1);
        tick(); idle_inputs();
        check("x0_fwd0_wen", {31'd0, fwd_0_wen}, 0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rd_wen) cnt++;
        end
        check("x0_no_commit", cnt, 0);

        // Asynchronous reset with results in flight; they are discarded
        drive_issue(15, 0);
        drive_result(4, 0, 32'h0000_0044, 0, 0);
        tick(); idle_inputs();
        drive_result(6, 0, 32'h0000_0066, 0, 0);
        tick(); idle_inputs();
        check("mid_pending15", dut.r_pending, 32'h0000_8000);
        check("mid_fwd1_wen", {31'd0, fwd_1_wen}, 1);
        resetn = 0; #1;
        check("arst_fwd0_wen", {31'd0, fwd_0_wen}, 0);
        check("arst_fwd0_addr", {27'd0, fwd_0_addr}, 0);
        check("arst_fwd0_data", fwd_0_wdata, 0);
        check("arst_fwd1_wen", {31'd0, fwd_1_wen}, 0);
        check("arst_fwd1_addr", {27'd0, fwd_1_addr}, 0);
        check("arst_rd_wen", {31'd0, rd_wen}, 0);
        check("arst_rd_addr", {27'd0, rd_addr}, 0);
        check("arst_pending", dut.r_pending, 0);
        check("arst_res_ready", {31'd0, res_ready}, 1);
        check("arst_iss_ready", {31'd0, iss_ready}, 1);
        repeat (2) tick();
        resetn = 1;
        repeat (4) tick();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
